mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port of the 5-stage pipelined core between instruction
//  fetch (IF) and the load/store unit (MEM stage). Grants one requester at a time, drives
//  the memory handshake, returns read data to the owner and drops fetches killed by flush.
//  Sits between the IF/MEM stages and the unified instruction/data memory inside main.
// PARAMETERS
//  ADDR_W          32            address width
//  DATA_W          32            data width
//  MAX_LSU_STREAK  4             consecutive LSU wins against a pending fetch before fetch is forced
//  TIMEOUT_CYC     64            cycles with o_mem_req high and no ack before abort
//  ERR_DATA        32'h0000_0013 data returned on abort (RV32I NOP)
// PORTS
//  i_clk        in   1       clock, rising edge
//  i_rst        in   1       asynchronous, active-low reset
//  i_if_req     in   1       fetch request; held with i_if_addr until o_if_gnt
//  i_if_addr    in   ADDR_W  fetch address (PC)
//  i_flush      in   1       pipeline flush (mispredict/jump redirect)
//  o_if_gnt     out  1       fetch accepted this cycle
//  o_if_rvalid  out  1       fetch data valid, 1-cycle pulse
//  o_if_rdata   out  DATA_W  instruction word
//  i_ls_req     in   1       load/store request; held with all i_ls_* until o_ls_gnt
//  i_ls_we      in   1       1 = store
//  i_ls_addr    in   ADDR_W  load/store address
//  i_ls_wdata   in   DATA_W  store data
//  i_ls_bmask   in   4       store byte enables
//  o_ls_gnt     out  1       load/store accepted this cycle
//  o_ls_rvalid  out  1       load data / store completion, 1-cycle pulse
//  o_ls_rdata   out  DATA_W  load data (0 for stores)
//  o_mem_req    out  1       memory request, held until i_mem_ack
//  o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask  out  1/ADDR_W/DATA_W/4  registered request fields
//  i_mem_ack    in   1       memory completion, 1-cycle pulse
//  i_mem_rdata  in   DATA_W  read data, valid with i_mem_ack
//  o_err        out  1       sticky timeout flag
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; streak 0; drop flag 0; o_err 0.
//  - FSM IDLE/BUSY_IF/BUSY_LS. Grants only in IDLE; o_*_gnt is combinational in IDLE.
//  - Arbitration in IDLE: LSU wins unless streak==MAX_LSU_STREAK and fetch pending; flush
//    in the same cycle blocks fetch grant (LSU may still be granted).
//  - Streak: +1 on LSU grant while i_if_req & ~i_flush; cleared on fetch grant or when fetch
//    not pending; saturates at MAX_LSU_STREAK.
//  - On grant: request fields registered; o_mem_req high from next cycle until ack cycle inclusive.
//  - Ack in BUSY_x: o_mem_req low next cycle; o_x_rvalid pulses next cycle with captured
//    i_mem_rdata; FSM -> IDLE, so next grant is possible the cycle after ack.
//  - Minimum latency: gnt cycle 0, ack cycle 1, rvalid cycle 2; throughput 1 txn / 2 cycles.
//  - Flush while BUSY_IF or in its ack cycle: drop flag set; transaction completes, o_if_rvalid
//    suppressed. Flush never affects LSU transactions.
//  - Timeout: counter runs in BUSY; at TIMEOUT_CYC: o_mem_req low, rvalid pulses with ERR_DATA
//    (drop still applies to fetch), o_err set until reset, FSM -> IDLE.
//  - i_mem_ack in IDLE ignored. Reset mid-transaction aborts silently; no rvalid.
// STRUCTURE
//  - mem_arb_pkg: arb_state_e {IDLE,BUSY_IF,BUSY_LS}, owner_e {OWN_IF,OWN_LS}, ERR_DATA default.
//  - Sub-module arb_timeout_ctr: clear/enable/expire counter, parameter TIMEOUT_CYC.
// TESTING
//  - Fetch only, addr 0x100, ack 1 cycle after req -> gnt c0, rvalid c2, rdata=mem[0x100].
//  - IF+LS both at c0, LS load 0x2000 -> LS granted first; fetch granted after LS ack.
//  - LS req every cycle, IF pending -> fetch forced after exactly 4 LSU grants.
//  - Fetch granted, i_flush at c1, ack c3 -> o_if_rvalid stays 0; next fetch grant c4.
//  - Store 0xCAFEBABE bmask 4'b0011 -> o_mem_bmask=4'b0011, o_ls_rvalid pulse, rdata=0.
//  - No ack for 64 cycles -> rvalid with 0x00000013, o_err=1, o_mem_req low.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // RV32I NOP: a fetch aborted by timeout decodes as a harmless instruction.
  localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory handshakes around the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_bmask;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_bmask;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;

  modport slave (
    input  if_req, if_addr, flush, ls_req, ls_we, ls_addr, ls_wdata, ls_bmask,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, err
  );

  modport master (
    output if_req, if_addr, flush, ls_req, ls_we, ls_addr, ls_wdata, ls_bmask,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, err
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Watchdog for an outstanding memory request: expire flags the TIMEOUT_CYC-th enabled cycle.
module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = en & (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the load/store unit,
// with LSU priority bounded by a streak limit, fetch kill on flush and a request watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                MAX_LSU_STREAK = 4,
  parameter int                TIMEOUT_CYC    = 64,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(ERR_DATA_DEF)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);

  arb_state_e        state, state_nxt;
  owner_e            owner;
  logic [SW-1:0]     streak;
  logic              drop;
  logic              if_pend, force_if, if_gnt, ls_gnt, done, expire;
  logic [DATA_W-1:0] rd_data;

  logic              mem_req_p1, mem_we_p1, if_rvalid_p1, ls_rvalid_p1, err_p1;
  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_wdata_p1, if_rdata_p1, ls_rdata_p1;
  logic [3:0]        mem_bmask_p1;

  // A flushed fetch is never pending; only a live fetch can force the LSU aside.
  assign if_pend  = bus.if_req & ~bus.flush;
  assign force_if = if_pend & (streak == SW'(MAX_LSU_STREAK));
  assign owner    = (state == BUSY_LS) ? OWN_LS : OWN_IF;
  assign rd_data  = bus.mem_ack ? bus.mem_rdata : ERR_DATA;

  arb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr    (state == IDLE),
    .en     (state != IDLE),
    .expire (expire)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (i_rst) begin
          if (bus.ls_req && !force_if) begin
            ls_gnt    = 1'b1;
            state_nxt = BUSY_LS;
          end else if (if_pend) begin
            if_gnt    = 1'b1;
            state_nxt = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (bus.mem_ack || expire) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      streak <= '0;
    end else if (if_gnt || !if_pend) begin
      streak <= '0;
    end else if (ls_gnt && streak != SW'(MAX_LSU_STREAK)) begin
      streak <= streak + SW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                              drop <= 1'b0;
    else if (done)                           drop <= 1'b0;
    else if (state == BUSY_IF && bus.flush)  drop <= 1'b1;
  end

  // Grant cycle -> request registers; completion cycle -> response registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mem_req_p1   <= 1'b0;
      mem_we_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      mem_bmask_p1 <= '0;
      if_rvalid_p1 <= 1'b0;
      if_rdata_p1  <= '0;
      ls_rvalid_p1 <= 1'b0;
      ls_rdata_p1  <= '0;
      err_p1       <= 1'b0;
    end else begin
      if_rvalid_p1 <= 1'b0;
      ls_rvalid_p1 <= 1'b0;
      if (ls_gnt) begin
        mem_req_p1   <= 1'b1;
        mem_we_p1    <= bus.ls_we;
        mem_addr_p1  <= bus.ls_addr;
        mem_wdata_p1 <= bus.ls_wdata;
        mem_bmask_p1 <= bus.ls_bmask;
      end else if (if_gnt) begin
        mem_req_p1   <= 1'b1;
        mem_we_p1    <= 1'b0;
        mem_addr_p1  <= bus.if_addr;
        mem_wdata_p1 <= '0;
        mem_bmask_p1 <= '0;
      end else if (done) begin
        mem_req_p1 <= 1'b0;
        if (owner == OWN_LS) begin
          ls_rvalid_p1 <= 1'b1;
          ls_rdata_p1  <= (bus.mem_ack && mem_we_p1) ? '0 : rd_data;
        end else if (!(drop || bus.flush)) begin
          if_rvalid_p1 <= 1'b1;
          if_rdata_p1  <= rd_data;
        end
        if (!bus.mem_ack) err_p1 <= 1'b1;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_req   = mem_req_p1;
  assign bus.mem_we    = mem_we_p1;
  assign bus.mem_addr  = mem_addr_p1;
  assign bus.mem_wdata = mem_wdata_p1;
  assign bus.mem_bmask = mem_bmask_p1;
  assign bus.if_rvalid = if_rvalid_p1;
  assign bus.if_rdata  = if_rdata_p1;
  assign bus.ls_rvalid = ls_rvalid_p1;
  assign bus.ls_rdata  = ls_rdata_p1;
  assign bus.err       = err_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, a simple memory responder, and hand-computed expectations per scenario.
module tb_mem_port_arbiter;

  localparam int          MAX_LSU_STREAK = 4;
  localparam int          TIMEOUT_CYC    = 64;
  localparam logic [31:0] ERR_WORD       = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(MAX_LSU_STREAK), .TIMEOUT_CYC(TIMEOUT_CYC),
    .ERR_DATA(ERR_WORD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ack_lat = 0;
  bit stray = 1'b0;

  int if_gnt_cyc = 0, ls_gnt_cyc = 0, if_rv_cyc = 0, ls_rv_cyc = 0;
  int if_rv_cnt = 0, ls_rv_cnt = 0, ls_since_if = 0, ls_before_if = 0;
  logic [31:0] if_rv_data = '0, ls_rv_data = '0, last_wdata = '0;
  logic [3:0]  last_bmask = '0;
  logic        last_we = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    bit g;
    int b;
    g = 1'b0;
    b = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    while (!g && b < 200) begin
      @(negedge clk);
      g = bus.if_gnt;
      tick();
      b++;
    end
    bus.if_req = 1'b0;
    chk("fetch_granted", 32'(g), 32'd1);
  endtask

  task automatic ls_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] bm);
    bit g;
    int b;
    g = 1'b0;
    b = 0;
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_addr  = a;
    bus.ls_wdata = wd;
    bus.ls_bmask = bm;
    while (!g && b < 200) begin
      @(negedge clk);
      g = bus.ls_gnt;
      tick();
      b++;
    end
    bus.ls_req = 1'b0;
    chk("ls_granted", 32'(g), 32'd1);
  endtask

  // Memory: acks ack_lat cycles after the request first shows (never when ack_lat < 0).
  initial begin : responder
    int  rc;
    bit  acked;
    rc    = 0;
    acked = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ack = stray;
      if (stray) bus.mem_rdata = 32'hDEAD_BEEF;
      if (!rst_n || !bus.mem_req) begin
        rc    = 0;
        acked = 1'b0;
      end else if (!acked) begin
        if (ack_lat >= 0 && rc == ack_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          acked         = 1'b1;
        end
        rc++;
      end
    end
  end

  // Reference model: owner/age/streak/drop bookkeeping, compared each cycle at negedge.
  initial begin : compare
    int          m_busy, m_age, m_streak;
    bit          m_drop, m_req, m_we, m_ifv, m_lsv, m_err;
    bit          ifok, e_ifg, e_lsg, nifv, nlsv;
    logic [31:0] m_addr, m_wdata, m_ifd, m_lsd;
    logic [3:0]  m_bmask;
    m_busy = 0; m_age = 0; m_streak = 0;
    m_drop = 0; m_req = 0; m_we = 0; m_ifv = 0; m_lsv = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_ifd = '0; m_lsd = '0; m_bmask = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_age = 0; m_streak = 0;
        m_drop = 0; m_req = 0; m_we = 0; m_ifv = 0; m_lsv = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_bmask = '0;
      end
      e_ifg = 1'b0;
      e_lsg = 1'b0;
      ifok  = bus.if_req && !bus.flush;
      if (rst_n && m_busy == 0) begin
        e_lsg = bus.ls_req && !(ifok && m_streak >= MAX_LSU_STREAK);
        e_ifg = ifok && !e_lsg;
      end

      chk("if_gnt", 32'(bus.if_gnt), 32'(e_ifg));
      chk("ls_gnt", 32'(bus.ls_gnt), 32'(e_lsg));
      chk("mem_req", 32'(bus.mem_req), 32'(m_req));
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(m_ifv));
      chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(m_lsv));
      chk("err", 32'(bus.err), 32'(m_err));
      if (m_req) begin
        chk("mem_we", 32'(bus.mem_we), 32'(m_we));
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("mem_bmask", 32'(bus.mem_bmask), 32'(m_bmask));
      end
      if (m_ifv) chk("if_rdata", bus.if_rdata, m_ifd);
      if (m_lsv) chk("ls_rdata", bus.ls_rdata, m_lsd);

      if (bus.if_gnt === 1'b1) begin
        if_gnt_cyc   = cyc;
        ls_before_if = ls_since_if;
        ls_since_if  = 0;
      end
      if (bus.ls_gnt === 1'b1) begin
        ls_gnt_cyc = cyc;
        ls_since_if++;
      end
      if (bus.if_rvalid === 1'b1) begin
        if_rv_cyc  = cyc;
        if_rv_data = bus.if_rdata;
        if_rv_cnt++;
      end
      if (bus.ls_rvalid === 1'b1) begin
        ls_rv_cyc  = cyc;
        ls_rv_data = bus.ls_rdata;
        ls_rv_cnt++;
      end
      if (bus.mem_req === 1'b1) begin
        last_we    = bus.mem_we;
        last_wdata = bus.mem_wdata;
        last_bmask = bus.mem_bmask;
      end

      if (rst_n) begin
        nifv = 1'b0;
        nlsv = 1'b0;
        if (m_busy != 0) begin
          m_age++;
          if (bus.mem_ack || m_age == TIMEOUT_CYC) begin
            m_req = 1'b0;
            if (m_busy == 2) begin
              nlsv  = 1'b1;
              m_lsd = !bus.mem_ack ? ERR_WORD : (m_we ? 32'h0 : bus.mem_rdata);
            end else if (!(m_drop || bus.flush)) begin
              nifv  = 1'b1;
              m_ifd = bus.mem_ack ? bus.mem_rdata : ERR_WORD;
            end
            if (!bus.mem_ack) m_err = 1'b1;
            m_drop = 1'b0;
            m_busy = 0;
          end else if (m_busy == 1 && bus.flush) begin
            m_drop = 1'b1;
          end
        end else if (e_lsg) begin
          m_busy = 2; m_age = 0; m_req = 1'b1;
          m_we = bus.ls_we; m_addr = bus.ls_addr; m_wdata = bus.ls_wdata; m_bmask = bus.ls_bmask;
        end else if (e_ifg) begin
          m_busy = 1; m_age = 0; m_req = 1'b1;
          m_we = 1'b0; m_addr = bus.if_addr; m_wdata = '0; m_bmask = '0;
        end
        m_ifv = nifv;
        m_lsv = nlsv;
        if (e_ifg || !ifok) m_streak = 0;
        else if (e_lsg && m_streak < MAX_LSU_STREAK) m_streak++;
      end
    end
  end

  initial begin : stim
    int c0, v0, w0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_bmask = '0;
    repeat (2) tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Lone fetch, immediate ack.
    ack_lat = 0;
    v0 = if_rv_cnt;
    fetch(32'h100);
    repeat (3) tick();
    chk("t1_latency", 32'(if_rv_cyc - if_gnt_cyc), 32'd2);
    chk("t1_rdata", if_rv_data, 32'h0100_FEFF);
    chk("t1_rvalid_cnt", 32'(if_rv_cnt - v0), 32'd1);

    // Simultaneous requests: LSU first, fetch right after the LSU ack.
    fork
      fetch(32'h180);
      ls_op(1'b0, 32'h2000, 32'h0, 4'h0);
    join
    repeat (4) tick();
    chk("t2_if_after_ls", 32'(if_gnt_cyc - ls_gnt_cyc), 32'd2);
    chk("t2_ls_rdata", ls_rv_data, 32'h2000_DFFF);
    chk("t2_if_rdata", if_rv_data, 32'h0180_FE7F);

    // LSU hammering with a fetch waiting: fetch forced after the streak limit.
    fork
      fetch(32'h500);
      begin
        for (int i = 0; i < 6; i++) ls_op(1'b0, 32'h3000 + 32'(i * 4), 32'h0, 4'h0);
      end
    join
    repeat (4) tick();
    chk("t3_ls_streak", 32'(ls_before_if), 32'd4);

    // Flush while a fetch is outstanding: its data is dropped, the redirect goes next.
    ack_lat = 2;
    v0 = if_rv_cnt;
    fetch(32'h200);
    c0 = if_gnt_cyc;
    fork
      fetch(32'h300);
      begin
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
      end
    join
    repeat (6) tick();
    chk("t4_regrant_cycle", 32'(if_gnt_cyc - c0), 32'd4);
    chk("t4_rvalid_cnt", 32'(if_rv_cnt - v0), 32'd1);
    chk("t4_rdata", if_rv_data, 32'h0300_FCFF);

    // Store: byte mask passes through, completion returns zero data.
    ack_lat = 0;
    v0 = ls_rv_cnt;
    ls_op(1'b1, 32'h40, 32'hCAFE_BABE, 4'b0011);
    repeat (3) tick();
    chk("t5_bmask", 32'(last_bmask), 32'h3);
    chk("t5_we", 32'(last_we), 32'd1);
    chk("t5_wdata", last_wdata, 32'hCAFE_BABE);
    chk("t5_rvalid_cnt", 32'(ls_rv_cnt - v0), 32'd1);
    chk("t5_rdata", ls_rv_data, 32'h0);

    // Flush does not touch a load in flight.
    v0 = ls_rv_cnt;
    fork
      ls_op(1'b0, 32'h2400, 32'h0, 4'h0);
      begin
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
      end
    join
    repeat (3) tick();
    chk("t6_rvalid_cnt", 32'(ls_rv_cnt - v0), 32'd1);
    chk("t6_rdata", ls_rv_data, 32'h2400_DBFF);

    // Stray ack while idle is ignored.
    v0 = if_rv_cnt;
    w0 = ls_rv_cnt;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (2) tick();
    chk("t7_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t7_if_rv", 32'(if_rv_cnt - v0), 32'd0);
    chk("t7_ls_rv", 32'(ls_rv_cnt - w0), 32'd0);

    // Memory never answers: abort with NOP data and sticky error.
    ack_lat = -1;
    v0 = if_rv_cnt;
    fetch(32'h400);
    repeat (70) tick();
    chk("t8_latency", 32'(if_rv_cyc - if_gnt_cyc), 32'd65);
    chk("t8_rdata", if_rv_data, ERR_WORD);
    chk("t8_rvalid_cnt", 32'(if_rv_cnt - v0), 32'd1);
    chk("t8_err", 32'(bus.err), 32'd1);
    chk("t8_mem_req", 32'(bus.mem_req), 32'd0);

    // Normal traffic after the abort; error stays set.
    ack_lat = 0;
    fetch(32'h480);
    repeat (3) tick();
    chk("t9_rdata", if_rv_data, 32'h0480_FB7F);
    chk("t9_err_sticky", 32'(bus.err), 32'd1);

    // Reset in the middle of a transaction aborts silently.
    ack_lat = -1;
    v0 = if_rv_cnt;
    fetch(32'h600);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("t10_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t10_err", 32'(bus.err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    ack_lat = 0;
    fetch(32'h700);
    repeat (3) tick();
    chk("t10_rvalid_cnt", 32'(if_rv_cnt - v0), 32'd1);
    chk("t10_rdata", if_rv_data, 32'h0700_F8FF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
